// File: rtl/fp_mul_arbiter_if.sv
// Purpose : bundle of requester, multiplier and result signals for fp_mul_arbiter.
// Latency : n/a (wires only).
// Backpressure: valid/ready on both request (s*) and result (r*) sides.
// Ports   : s0/s1 request channels, mul_a/mul_b/mul_result multiplier link,
//           r0/r1 result channels, busy status.
interface fp_mul_arbiter_if #(
  parameter int XLEN = 32
);
  logic            s0_valid, s1_valid;
  logic            s0_ready, s1_ready;
  logic [XLEN-1:0] s0_a, s0_b, s1_a, s1_b;
  logic [XLEN-1:0] mul_a, mul_b;
  logic [XLEN-1:0] mul_result;
  logic            r0_valid, r1_valid;
  logic            r0_ready, r1_ready;
  logic [XLEN-1:0] r0_result, r1_result;
  logic            busy;

  // arbiter side
  modport slave (
    input  s0_valid, s1_valid, s0_a, s0_b, s1_a, s1_b, mul_result, r0_ready, r1_ready,
    output s0_ready, s1_ready, mul_a, mul_b, r0_valid, r1_valid, r0_result, r1_result, busy
  );

  // requester / multiplier / consumer side
  modport master (
    output s0_valid, s1_valid, s0_a, s0_b, s1_a, s1_b, mul_result, r0_ready, r1_ready,
    input  s0_ready, s1_ready, mul_a, mul_b, r0_valid, r1_valid, r0_result, r1_result, busy
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Purpose : round-robin share of one FP multiplier between two requesters,
//           products returned through per-requester result FIFOs.
// Latency : accept in cycle n -> operands out n+1 -> result visible n+LAT+1.
// Backpressure: a requester is held off while its in-flight + queued results
//           would overflow its FIFO, so no product is ever dropped.
// Ports   : clk, rst (async active-high), bus (fp_mul_arbiter_if.slave).

// Small circular-buffer FIFO; pointers carry one extra wrap bit.
module fp_mul_arbiter_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic                     vld,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         pop_ok;

  assign count  = wr_ptr - rd_ptr;
  assign vld    = (count != '0);
  assign head   = mem[rd_ptr[AW-1:0]];
  // popping an empty FIFO is a no-op
  assign pop_ok = pop & vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module fp_mul_arbiter #(
  parameter int XLEN  = 32,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  fp_mul_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]   inflight [2];
  logic [CW-1:0]   count    [2];
  logic [1:0]      elig, cand, acc, push, pop, fvld;
  logic [XLEN-1:0] fhead    [2];
  logic [XLEN-1:0] mul_a_q, mul_b_q;
  logic            last;
  logic [LAT-1:0]  tag_v, tag_id;
  logic            ret_v, ret_id;

  // Credit check: results already owed plus results queued must leave room.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++)
      elig[i] = ({1'b0, inflight[i]} + {1'b0, count[i]}) < (CW+1)'(DEPTH);
  end

  assign cand = {bus.s1_valid, bus.s0_valid} & elig;

  // Ready never looks at the requester's own valid; it only yields when the
  // other side is a candidate and owns the tie (last names the previous winner).
  assign bus.s0_ready = elig[0] & ~(cand[1] & ~last);
  assign bus.s1_ready = elig[1] & ~(cand[0] &  last);
  assign acc = {bus.s1_valid & bus.s1_ready, bus.s0_valid & bus.s0_ready};

  // Issue: operand registers plus a tag pipe that mirrors the multiplier depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      last    <= 1'b1;
      tag_v   <= '0;
      tag_id  <= '0;
    end else begin
      if (acc[0]) begin
        mul_a_q <= bus.s0_a;
        mul_b_q <= bus.s0_b;
        last    <= 1'b0;
      end else if (acc[1]) begin
        mul_a_q <= bus.s1_a;
        mul_b_q <= bus.s1_b;
        last    <= 1'b1;
      end
      tag_v[0]  <= |acc;
      tag_id[0] <= acc[1];
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign bus.mul_a = mul_a_q;
  assign bus.mul_b = mul_b_q;

  // Retire: the tag leaving the pipe lines up with the product on mul_result.
  assign ret_v  = tag_v[LAT-1];
  assign ret_id = tag_id[LAT-1];
  assign push   = {ret_v & ret_id, ret_v & ~ret_id};
  assign pop    = {bus.r1_ready, bus.r0_ready};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) inflight[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        inflight[i] <= inflight[i] + CW'(acc[i]) - CW'(push[i]);
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    fp_mul_arbiter_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[g]),
      .push_dat (bus.mul_result),
      .pop      (pop[g]),
      .vld      (fvld[g]),
      .head     (fhead[g]),
      .count    (count[g])
    );
  end

  assign bus.r0_valid  = fvld[0];
  assign bus.r1_valid  = fvld[1];
  assign bus.r0_result = fhead[0];
  assign bus.r1_result = fhead[1];

  assign bus.busy = (inflight[0] != '0) | (inflight[1] != '0) |
                    (count[0] != '0)    | (count[1] != '0);
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Purpose : directed self-checking bench for fp_mul_arbiter with a
//           behavioural single-precision multiplier of latency LAT=2.
// Latency : n/a.
// Backpressure: consumer ready lines driven per scenario.
module tb_fp_mul_arbiter;
  localparam int XLEN  = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  fp_mul_arbiter_if #(.XLEN(XLEN)) bus();

  fp_mul_arbiter #(.XLEN(XLEN), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // IEEE single multiply for normal operands: the exact product fits in a
  // double, then round-to-nearest-even down to single.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] da, db, dp;
    logic [10:0] ea, eb, se;
    logic [22:0] m;
    logic [28:0] rem;
    logic        rup;
    ea  = {3'b0, a[30:23]} + 11'd896;
    eb  = {3'b0, b[30:23]} + 11'd896;
    da  = {a[31], ea, a[22:0], 29'd0};
    db  = {b[31], eb, b[22:0], 29'd0};
    dp  = $realtobits($bitstoreal(da) * $bitstoreal(db));
    se  = dp[62:52] - 11'd896;
    m   = dp[51:29];
    rem = dp[28:0];
    rup = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && m[0]);
    return {dp[63], se[7:0], m} + {31'd0, rup};
  endfunction

  // Multiplier model: one register stage after mul_a/mul_b gives LAT=2.
  logic [31:0] mreg;
  always @(posedge clk) mreg <= fmul(bus.mul_a, bus.mul_b);
  assign bus.mul_result = mreg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
    bus.s0_a = '0; bus.s0_b = '0; bus.s1_a = '0; bus.s1_b = '0;
    bus.r0_ready = 1'b0; bus.r1_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // check head of FIFO 0/1, pop it over the next edge
  task automatic pop_check(input int which, input logic [31:0] exp, input string tag);
    if (which == 0) begin
      chk({tag, "_v"}, bus.r0_valid, 1); chk(tag, bus.r0_result, exp); bus.r0_ready = 1'b1;
    end else begin
      chk({tag, "_v"}, bus.r1_valid, 1); chk(tag, bus.r1_result, exp); bus.r1_ready = 1'b1;
    end
    @(negedge clk);
    bus.r0_ready = 1'b0; bus.r1_ready = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  logic [31:0] bp_b [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] bp_p [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
  logic [31:0] expq [$];

  initial begin
    int n0, n1, sent, got, cyc;
    logic seen;
    logic [31:0] a, b;

    // ---------------- reset values
    idle();
    @(negedge clk); @(negedge clk);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    chk("rst_r0_valid", bus.r0_valid, 0);
    chk("rst_r1_valid", bus.r1_valid, 0);
    chk("rst_r0_result", bus.r0_result, 0);
    chk("rst_r1_result", bus.r1_result, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_s0_ready", bus.s0_ready, 1);
    chk("rst_s1_ready", bus.s1_ready, 1);
    rst = 1'b0;

    // ---------------- single request: 2.0 * 3.0
    bus.s0_valid = 1'b1; bus.s0_a = 32'h40000000; bus.s0_b = 32'h40400000;
    #1 chk("single_s0_ready", bus.s0_ready, 1);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.s0_valid = 1'b0;
        chk("single_mul_a", bus.mul_a, 32'h40000000);
        chk("single_mul_b", bus.mul_b, 32'h40400000);
      end
      chk("single_r0_valid", bus.r0_valid, (k == LAT + 1) ? 1 : 0);
      chk("single_r1_valid", bus.r1_valid, 0);
    end
    pop_check(0, 32'h40C00000, "single_r0_result");
    chk("single_r0_empty", bus.r0_valid, 0);
    chk("single_busy_idle", bus.busy, 0);

    // ---------------- contention: grants 0,1,0,1
    apply_reset();
    for (int j = 0; j < 4; j++) begin
      bus.s0_valid = 1'b1; bus.s0_a = 32'hBF000000; bus.s0_b = 32'hC0CCCCCC;
      bus.s1_valid = 1'b1; bus.s1_a = 32'hBF000000; bus.s1_b = 32'h40CCCCCC;
      #1;
      chk("cont_s0_ready", bus.s0_ready, (j % 2 == 0) ? 1 : 0);
      chk("cont_s1_ready", bus.s1_ready, (j % 2 == 1) ? 1 : 0);
      @(negedge clk);
    end
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
    repeat (3) @(negedge clk);
    pop_check(0, 32'h404CCCCC, "cont_r0_a");
    pop_check(0, 32'h404CCCCC, "cont_r0_b");
    chk("cont_r0_empty", bus.r0_valid, 0);
    pop_check(1, 32'hC04CCCCC, "cont_r1_a");
    pop_check(1, 32'hC04CCCCC, "cont_r1_b");
    chk("cont_r1_empty", bus.r1_valid, 0);

    // ---------------- backpressure on requester 0
    n0 = 0; n1 = 0;
    bus.r1_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.s0_valid = 1'b1; bus.s0_a = 32'h40000000; bus.s0_b = bp_b[n0 & 3];
      bus.s1_valid = 1'b1; bus.s1_a = 32'h3F800000; bus.s1_b = 32'h3F800000;
      #1;
      if (c >= 8) begin
        chk("bp_s0_stalled", bus.s0_ready, 0);
        chk("bp_s1_full_rate", bus.s1_ready, 1);
      end
      if (bus.s0_ready) n0++;
      if (bus.s1_ready) n1++;
      @(negedge clk);
    end
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
    chk("bp_s0_accepts", n0, DEPTH);
    chk("bp_s1_accepts", n1, 8);
    repeat (3) @(negedge clk);
    for (int j = 0; j < 4; j++) pop_check(0, bp_p[j], "bp_r0_order");
    chk("bp_r0_empty", bus.r0_valid, 0);
    chk("bp_busy_idle", bus.busy, 0);

    // ---------------- simultaneous push and pop on FIFO1
    for (int j = 0; j < 3; j++) begin
      bus.s1_valid = 1'b1; bus.s1_a = 32'h40000000; bus.s1_b = bp_b[j];
      #1 chk("pp_s1_ready", bus.s1_ready, 1);
      @(negedge clk);
    end
    bus.s1_valid = 1'b0;
    @(negedge clk);                       // two results queued, third retiring next edge
    chk("pp_head0", bus.r1_result, bp_p[0]);
    bus.r1_ready = 1'b1;                  // pop on the same edge as the retire
    @(negedge clk);
    bus.r1_ready = 1'b0;
    pop_check(1, bp_p[1], "pp_head1");
    pop_check(1, bp_p[2], "pp_head2");
    chk("pp_r1_empty", bus.r1_valid, 0);
    chk("pp_busy_idle", bus.busy, 0);

    // ---------------- reset mid-flight
    bus.s0_valid = 1'b1; bus.s0_a = 32'h40000000; bus.s0_b = 32'h40400000;
    bus.s1_valid = 1'b1; bus.s1_a = 32'h40000000; bus.s1_b = 32'h40400000;
    @(negedge clk); @(negedge clk);
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
    chk("mid_busy_before", bus.busy, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_mul_a", bus.mul_a, 0);
    chk("mid_mul_b", bus.mul_b, 0);
    chk("mid_r0_valid", bus.r0_valid, 0);
    chk("mid_r1_valid", bus.r1_valid, 0);
    chk("mid_r0_result", bus.r0_result, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_s0_ready", bus.s0_ready, 1);
    chk("mid_s1_ready", bus.s1_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | bus.r0_valid | bus.r1_valid;
    end
    chk("mid_no_flushed_results", seen, 0);
    bus.s0_valid = 1'b1; bus.s0_a = 32'h3F800000; bus.s0_b = 32'h3F800000;
    bus.s1_valid = 1'b1; bus.s1_a = 32'h40000000; bus.s1_b = 32'h3F800000;
    #1;
    chk("mid_tie_s0_ready", bus.s0_ready, 1);
    chk("mid_tie_s1_ready", bus.s1_ready, 0);
    @(negedge clk);
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
    chk("mid_tie_mul_a", bus.mul_a, 32'h3F800000);
    bus.r0_ready = 1'b1; bus.r1_ready = 1'b1;
    repeat (5) @(negedge clk);
    bus.r0_ready = 1'b0; bus.r1_ready = 1'b0;
    chk("mid_drain_busy", bus.busy, 0);

    // ---------------- wrap-around: 20 back-to-back from requester 1
    sent = 0; got = 0; cyc = 0;
    bus.r1_ready = 1'b1;
    while (got < 20 && cyc < 200) begin
      if (bus.r1_valid) begin
        if (expq.size() == 0) chk("wrap_unexpected", bus.r1_valid, 0);
        else begin
          chk("wrap_result", bus.r1_result, expq.pop_front());
          got++;
        end
      end
      if (sent < 20) begin
        a = rnd_op(); b = rnd_op();
        bus.s1_valid = 1'b1; bus.s1_a = a; bus.s1_b = b;
        #1 chk("wrap_s1_ready", bus.s1_ready, 1);
        if (bus.s1_ready) begin
          expq.push_back(fmul(a, b));
          sent++;
        end
      end else begin
        bus.s1_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.s1_valid = 1'b0;
    bus.r1_ready = 1'b0;
    chk("wrap_count", got, 20);
    chk("wrap_r0_idle", bus.r0_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Two-requester round-robin scheduler that shares one `FloatingMultiplication` datapath, which is 32-bit IEEE-754 single precision and has a fixed pipeline latency. It accepts operand pairs over valid/ready, issues at most one pair per cycle to the multiplier, and tags each pair through the multiplier pipeline. Each product is returned to the requester that issued it through a per-requester result FIFO. It sits between the two FP-issuing clients and the single shared multiplier instance.

## Interface
- `XLEN`, 32: operand/result width.
- `LAT`, 2: multiplier latency. A product is sampled `LAT` clock edges after the operand registers update; range 1..8.
- `DEPTH`, 4: entries per result FIFO, power of two, ≥ 2.

Clock and reset: one clock, `clk`. Reset is `rst`, asynchronous and active-high.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `s0_valid`, `s1_valid`  in  1  requester i has an operand pair.
- `s0_ready`, `s1_ready`  out  1  requester i's pair is accepted this cycle when valid.
- `s0_a`, `s0_b`, `s1_a`, `s1_b`  in  XLEN  operands.
- `mul_a`, `mul_b`  out  XLEN  registered operands driven to the multiplier.
- `mul_result`  in  XLEN  multiplier product.
- `r0_valid`, `r1_valid`  out  1  head of result FIFO i is valid.
- `r0_ready`, `r1_ready`  in  1  consumer i pops the head.
- `r0_result`, `r1_result`  out  XLEN  FIFO i head data.
- `busy`  out  1  any pair is in flight or any FIFO is non-empty.

## Operation
- **Eligibility:**
  - `elig_i = (inflight_i + count_i) < DEPTH`.
  - A pop in the current cycle does not add credit until the next cycle.
  - This guarantees that no result is ever dropped.
- **Arbitration:**
  - A requester is a candidate when `si_valid & elig_i`.
  - With one candidate, that candidate wins.
  - With two candidates, the requester not granted most recently wins.
  - The `last` pointer resets to 1, so requester 0 wins the first tie.
  - `last` updates only on an accept.
- **Ready:**
  - `si_ready = elig_i & ~(other requester is a candidate and wins the tie)`.
  - Ready depends only on eligibility and the other requester's valid, never on its own valid.
- **Issue:** on accept, `mul_a`/`mul_b` load the winner's operands. A tag shift register of depth `LAT` is pushed with {valid=1, id=i}. With no accept, the operand registers hold their value and a bubble (valid=0) is pushed.
- **Retire:**
  - When the tag-register output has valid set, `mul_result` is written into FIFO[id] on the same edge, and `inflight_id` decrements.
  - `mul_result` passes through unmodified; rounding and exception handling are owned by the multiplier.
- **FIFO:**
  - Circular buffer with log2(DEPTH)+1-bit pointers, with wrap-around.
  - Push and pop in the same cycle are legal; count is unchanged.
  - A pop on an empty FIFO is ignored.
- **Ordering:** results return to each requester in that requester's acceptance order.
- **Reset mid-operation:** all in-flight pairs and FIFO contents are discarded. Counters and pointers clear, and `last` is set to 1.

## Timing
- Reset values:
  - `mul_a = mul_b = 0`.
  - `r0_valid = r1_valid = 0`, `r0_result = r1_result = 0`.
  - `busy = 0`.
  - `s0_ready = s1_ready = 1` (all credits free).
- Throughput: one accept per cycle, aggregate across both requesters.
- Latency, from an accept in cycle n:
  - `mul_a`/`mul_b` are valid in cycle n+1.
  - The product is captured at the end of cycle n+LAT.
  - `ri_valid` asserts in cycle n+LAT+1 if FIFO i was empty.
- `ri_valid`/`ri_result` are register outputs; they are stable until popped.
- `si_ready` is combinational from registered state and the other requester's `valid`.
- `busy` is registered-state combinational. It deasserts in the cycle after the last pop once no pair is in flight.

## Test plan
- **Single request:** reset, then requester 0 sends A=0x40000000, B=0x40400000. Required: `r0_valid` is high exactly LAT+1 cycles after accept, `r0_result`=0x40C00000, and `r1_valid` stays 0.
- **Contention:** both requesters hold valid for 4 cycles. Requester 0 sends 0xBF000000×0xC0CCCCCC; requester 1 sends 0xBF000000×0x40CCCCCC. Required:
  - Grants alternate 0,1,0,1.
  - FIFO0 receives 0x404CCCCC twice.
  - FIFO1 receives 0xC04CCCCC twice.
- **Backpressure:** hold `r0_ready`=0 while requester 0 streams. Required:
  - `s0_ready` drops after exactly DEPTH accepts (4).
  - Requester 1 keeps full throughput.
  - After `r0_ready`=1, all 4 results pop in order.
- **Simultaneous push and pop:** FIFO1 count is 2, `r1_ready`=1, and a retire to FIFO1 occurs in the same cycle. Required: count stays 2, head advances, and there is no loss or duplication.
- **Reset mid-flight:** assert `rst` asynchronously one cycle after 2 accepts. Required:
  - Outputs return immediately to their reset values.
  - No `ri_valid` ever appears for the flushed pairs.
  - The first tie after reset goes to requester 0.
- **Wrap-around:** 20 back-to-back requests from requester 1 with `r1_ready`=1 and a randomised operand set. Required: every result matches a reference model in order, including across pointer wrap.
